// File: rtl/q_sample_ctrl.sv
// Delayed sample-and-hold controller: a request picks a slow or fast wait class,
// waits out the count, then updates q. Optional q_par output under Q_SAMPLE_CTRL_PARITY_EN.
module q_sample_ctrl #(
  parameter int WIDTH     = 8,
  parameter int SLOW_WAIT = 3,
  parameter int FAST_WAIT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data,
  input  logic             reset_sel,
  input  logic             cntrl,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             busy,
  output logic             err_nopath,
  output logic             err_overrun
`ifdef Q_SAMPLE_CTRL_PARITY_EN
  ,
  output logic             q_par
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  localparam logic [3:0] SLOW_CNT = 4'(SLOW_WAIT);
  localparam logic [3:0] FAST_CNT = 4'(FAST_WAIT);

  state_t           state_r, state_s;
  logic [3:0]       cnt_r, cnt_s;
  logic [WIDTH-1:0] data_lat_r, data_lat_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic             q_valid_r, q_valid_s;
  logic             busy_r, busy_s;
  logic             err_nopath_r, err_nopath_s;
  logic             err_overrun_r, err_overrun_s;

  // Next-state, datapath and flag computation; all outputs are registered below.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    data_lat_s    = data_lat_r;
    q_s           = q_r;
    q_valid_s     = 1'b0;
    err_nopath_s  = err_nopath_r;
    err_overrun_s = err_overrun_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (reset_sel) begin
            data_lat_s = data;
            cnt_s      = SLOW_CNT;
            state_s    = ST_WAIT;
          end else if (cntrl) begin
            data_lat_s = data;
            cnt_s      = FAST_CNT;
            state_s    = ST_WAIT;
          end else begin
            err_nopath_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (in_valid) begin
          err_overrun_s = 1'b1;
        end else begin
          err_overrun_s = err_overrun_r;
        end
        // The count parks at 1 rather than wrapping; the last wait cycle hands off to CAPTURE.
        if (cnt_r <= 4'd1) begin
          state_s   = ST_CAPTURE;
          q_s       = data_lat_r;
          q_valid_s = 1'b1;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_CAPTURE: begin
        if (in_valid) begin
          err_overrun_s = 1'b1;
        end else begin
          err_overrun_s = err_overrun_r;
        end
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 4'd0;
      data_lat_r    <= '0;
      q_r           <= '0;
      q_valid_r     <= 1'b0;
      busy_r        <= 1'b0;
      err_nopath_r  <= 1'b0;
      err_overrun_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      data_lat_r    <= data_lat_s;
      q_r           <= q_s;
      q_valid_r     <= q_valid_s;
      busy_r        <= busy_s;
      err_nopath_r  <= err_nopath_s;
      err_overrun_r <= err_overrun_s;
    end
  end

  assign q           = q_r;
  assign q_valid     = q_valid_r;
  assign busy        = busy_r;
  assign err_nopath  = err_nopath_r;
  assign err_overrun = err_overrun_r;

`ifdef Q_SAMPLE_CTRL_PARITY_EN
  function automatic logic even_par(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic q_par_r;

  // Parity register tracks q so both update on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_par_r <= 1'b0;
    end else begin
      q_par_r <= even_par(q_s);
    end
  end

  assign q_par = q_par_r;
`endif

endmodule
